i2c_uart_tx_stage: RTL and testbench

Downstream stage of the I2C-to-UART bridge. It accepts bytes completed by the I2C slave receiver, buffers them in a small FIFO and serialises each one on a UART 8N1 line. The receive path must already be synchronised into the system clock domain: one single-cycle `DATA_VALID` pulse per byte.

---
 rtl/i2c_uart_tx_stage.sv | 181 ++++++++++++++++++
 tb/tb_i2c_uart_tx_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_uart_tx_stage.sv
// I2C-to-UART bridge transmit stage. Bytes from the I2C receiver are queued in a
// small FIFO and sent as UART 8N1 frames, LSB first.
module i2c_uart_tx_stage #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [7:0]                    DATA_IN,
  input  logic                          DATA_VALID,
  output logic                          TX,
  output logic                          BUSY,
  output logic                          FIFO_FULL,
  output logic                          OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  logic           drop;
  logic [7:0]     head;

  logic [BW-1:0]  baud_cnt;
  logic [BW-1:0]  baud_next;
  logic           baud_done;
  logic [2:0]     bit_idx;
  logic [2:0]     bit_next;
  logic [7:0]     shift;
  logic [7:0]     shift_next;
  logic           tx_reg;
  logic           tx_next;
  logic           overflow_reg;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = DATA_VALID && (!full || pop);
  assign drop  = DATA_VALID && full && !pop;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= DATA_IN;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_reg   <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      tx_reg   <= tx_next;
    end
  end

  // TX is computed one cycle ahead so the line itself comes straight from a flop.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = tx_reg;
    pop        = 1'b0;

    unique case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = head;
          baud_next  = '0;
          tx_next    = 1'b0;
          state_next = START;
        end
      end

      START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = shift[0];
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_next  = '0;
          shift_next = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            bit_next = bit_idx + 1'b1;
            tx_next  = shift[1];
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end

      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          // A queued byte starts its frame immediately, with no idle bit between.
          if (!empty) begin
            pop        = 1'b1;
            shift_next = head;
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            tx_next    = 1'b1;
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end

      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign TX         = tx_reg;
  assign BUSY       = (state != IDLE) || !empty;
  assign FIFO_FULL  = full;
  assign OVERFLOW   = overflow_reg;
  assign FIFO_COUNT = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_i2c_uart_tx_stage.sv
// Bench for i2c_uart_tx_stage: queue-based line model checked every cycle, a UART
// decoder on TX, and directed scenarios with hand-computed expectations.
module tb_i2c_uart_tx_stage;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * N;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic [7:0] DATA_IN = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       TX;
  logic       BUSY;
  logic       FIFO_FULL;
  logic       OVERFLOW;
  logic [2:0] FIFO_COUNT;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  i2c_uart_tx_stage #(.CLKS_PER_BIT(N), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
    .TX(TX), .BUSY(BUSY), .FIFO_FULL(FIFO_FULL), .OVERFLOW(OVERFLOW),
    .FIFO_COUNT(FIFO_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Line model: a byte queue plus the frame in flight and its cycle offset.
  logic [7:0] mq[$];
  logic [7:0] m_log[$];
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_pop;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mq.delete();
      m_log.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
    end else begin
      m_pop = (mq.size() > 0) && (!m_active || m_t == FRAME - 1);
      if (m_pop) begin
        m_cur    = mq.pop_front();
        m_log.push_back(m_cur);
        m_active = 1'b1;
        m_t      = 0;
      end else if (m_active) begin
        if (m_t == FRAME - 1) m_active = 1'b0;
        else m_t++;
      end
      if (DATA_VALID) begin
        if (mq.size() < DEPTH) mq.push_back(DATA_IN);
        else m_ovf = 1'b1;
      end
    end
  end

  function automatic logic exp_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_t / N;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  always @(negedge CLK) begin
    if (chk_en && RST_N) begin
      check("model_tx", TX, exp_tx());
      check("model_busy", BUSY, m_active || (mq.size() > 0));
      check("model_full", FIFO_FULL, mq.size() == DEPTH);
      check("model_count", FIFO_COUNT, mq.size());
      check("model_overflow", OVERFLOW, m_ovf);
    end
  end

  // UART receiver sampling each bit in its middle.
  logic [7:0] rx_q[$];
  bit         rx_busy = 1'b0;
  int         rx_cnt = 0;
  int         rx_k;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_busy = 1'b0;
      rx_q.delete();
    end else if (!rx_busy) begin
      if (TX === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % N == N / 2) begin
        rx_k = rx_cnt / N;
        if (rx_k >= 1 && rx_k <= 8) rx_byte[rx_k-1] = TX;
        else if (rx_k == 9) begin
          check("rx_stop_bit", TX, 1);
          rx_q.push_back(rx_byte);
          rx_busy = 1'b0;
        end
      end
    end
  end

  logic [7:0] exp_q[$];

  task automatic check_rx(input string name);
    check({name, "_rx_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check({name, "_rx_byte"}, rx_q[i], exp_q[i]);
    end
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    DATA_VALID = 1'b0;
    #1 RST_N = 1'b0;
    #1;
    check("rst_tx", TX, 1);
    check("rst_busy", BUSY, 0);
    check("rst_full", FIFO_FULL, 0);
    check("rst_overflow", OVERFLOW, 0);
    check("rst_count", FIFO_COUNT, 0);
    repeat (2) @(negedge CLK);
    RST_N  = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge CLK);
    DATA_VALID = 1'b1;
    DATA_IN    = b;
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge CLK);
      if (!BUSY) break;
    end
    check("idle_reached", k < 5000, 1);
    repeat (2) @(negedge CLK);
  endtask

  int seq_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    #2;
    do_reset();

    // Single byte 0xA5
    applyStimulus(8'hA5);
    check("a5_tx_before_start", TX, 1);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < N; j++) begin
        @(negedge CLK);
        check("a5_bit", TX, seq_a5[i]);
      end
    end
    check("a5_busy_in_stop", BUSY, 1);
    @(negedge CLK);
    check("a5_busy_after_stop", BUSY, 0);
    check("a5_overflow", OVERFLOW, 0);
    exp_q = {8'hA5};
    check_rx("a5");

    // Back-to-back 0x01, 0x80, 0xFF
    do_reset();
    @(negedge CLK); DATA_VALID = 1'b1; DATA_IN = 8'h01;
    @(negedge CLK); DATA_IN = 8'h80;
    @(negedge CLK); DATA_IN = 8'hFF;
    @(negedge CLK); DATA_VALID = 1'b0;
    check("b2b_count_2", FIFO_COUNT, 2);
    check("b2b_tx_start1", TX, 0);
    repeat (39) @(negedge CLK);
    check("b2b_count_1", FIFO_COUNT, 1);
    check("b2b_tx_start2", TX, 0);
    repeat (40) @(negedge CLK);
    check("b2b_count_0", FIFO_COUNT, 0);
    check("b2b_tx_start3", TX, 0);
    wait_idle();
    exp_q = {8'h01, 8'h80, 8'hFF};
    check_rx("b2b");

    // Overflow: six strobes, the last one dropped
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (i == 5) begin
        check("ovf_before_drop", OVERFLOW, 0);
        check("ovf_full", FIFO_FULL, 1);
      end
      DATA_VALID = 1'b1;
      DATA_IN    = 8'h10 + 8'(i);
    end
    @(negedge CLK);
    DATA_VALID = 1'b0;
    check("ovf_set", OVERFLOW, 1);
    check("ovf_count", FIFO_COUNT, 4);
    wait_idle();
    check("ovf_sticky", OVERFLOW, 1);
    exp_q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    check_rx("ovf");

    // Push on full in the same cycle the first frame's STOP ends
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      DATA_VALID = 1'b1;
      DATA_IN    = 8'h20 + 8'(i);
    end
    @(negedge CLK);
    DATA_VALID = 1'b0;
    check("pof_count_full", FIFO_COUNT, 4);
    check("pof_full", FIFO_FULL, 1);
    repeat (36) @(negedge CLK);
    check("pof_tx_stop", TX, 1);
    DATA_VALID = 1'b1;
    DATA_IN    = 8'h25;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    check("pof_overflow", OVERFLOW, 0);
    check("pof_count", FIFO_COUNT, 4);
    check("pof_tx_next_start", TX, 0);
    wait_idle();
    exp_q = {8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    check_rx("pof");

    // Reset during data bit 3 of 0x00
    do_reset();
    applyStimulus(8'h00);
    repeat (18) @(negedge CLK);
    check("midrst_tx_bit3", TX, 0);
    check("midrst_busy", BUSY, 1);
    do_reset();
    applyStimulus(8'h3C);
    wait_idle();
    exp_q = {8'h3C};
    check_rx("midrst");

    // Ten single bytes across the pointer wrap
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'(i));
      exp_q.push_back(8'(i));
      wait_idle();
      check("wrap_count_zero", FIFO_COUNT, 0);
    end
    check_rx("wrap");

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(negedge CLK);
      DATA_VALID = ($urandom_range(0, 9) == 0);
      DATA_IN    = 8'($urandom);
    end
    @(negedge CLK);
    DATA_VALID = 1'b0;
    wait_idle();
    exp_q = m_log;
    check_rx("rand");

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
